mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of all address ports.
REQ-002 Parameter: MAX_DATA_STREAK, default 4, maximum consecutive data grants while fetch waits; legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 Port: if_req  input  1  fetch request, held high until if_ack.
REQ-006 Port: if_addr  input  ADDR_W  fetch byte address, stable while if_req high.
REQ-007 Port: if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 Port: if_rdata  output  32  fetch read word, valid while if_ack high.
REQ-009 Port: d_req  input  1  data request, held high until d_ack.
REQ-010 Port: d_we  input  1  1 = store, 0 = load.
REQ-011 Port: d_addr  input  ADDR_W  data byte address.
REQ-012 Port: d_wdata  input  32  store data.
REQ-013 Port: d_be  input  4  store byte enables; bit i enables byte lane i.
REQ-014 Port: d_ack  output  1  one-cycle data completion pulse.
REQ-015 Port: d_rdata  output  32  load word, valid while d_ack high.
REQ-016 Port: mem_req  output  1  request to the shared memory, held until mem_ack.
REQ-017 Port: mem_we, mem_addr, mem_wdata, mem_be  output  1/ADDR_W/32/4  registered copy of the granted request.
REQ-018 Port: mem_ack  input  1  memory completion pulse; mem_rdata is valid in the same cycle.
REQ-019 Port: mem_rdata  input  32  memory read word.
REQ-020 Port: proto_err  output  1  sticky flag for an unexpected mem_ack.

Function
REQ-021 The FSM SHALL use the states IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D.
REQ-022 IDLE SHALL grant d_req over if_req, except when the streak counter equals MAX_DATA_STREAK and both are high; in that case it SHALL grant fetch.
REQ-023 On a grant, the arbiter SHALL register the requester's address, we, wdata and be into the mem_* outputs and move to BUSY_x; a fetch grant SHALL force mem_we=0 and mem_be=4'hF.
REQ-024 mem_req SHALL be 1 exactly in BUSY_I and BUSY_D; the mem_* outputs SHALL stay stable while mem_req is high.
REQ-025 A BUSY_x state with mem_ack=1 SHALL capture mem_rdata into x_rdata and move to RESP_x; without mem_ack it SHALL stay in BUSY_x indefinitely.
REQ-026 RESP_x SHALL assert x_ack for exactly one cycle and then return to IDLE unconditionally.
REQ-027 The arbiter SHALL NOT issue a new grant in RESP_x, so that requesters can drop req after ack.
REQ-028 Minimum latency: a request first sampled high at edge N SHALL cause mem_req high after edge N; zero-wait mem_ack in that cycle SHALL cause x_ack high after edge N+1; a back-to-back transaction SHALL cost 3 cycles.
REQ-029 The 4-bit streak counter SHALL increment, saturating at MAX_DATA_STREAK, on a data grant when if_req=1; it SHALL clear on a data grant when if_req=0 and on any fetch grant.
REQ-030 mem_ack in IDLE, RESP_I or RESP_D SHALL be ignored for state and data purposes, and SHALL set proto_err, which stays 1 until reset.
REQ-031 x_rdata SHALL hold its last captured value outside x_ack cycles.
REQ-032 For a store, d_rdata SHALL still capture mem_rdata; its value is don't-care for the requester.
REQ-033 if_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-034 Reset SHALL force IDLE, streak=0, proto_err=0, mem_req=0, if_ack=0, d_ack=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, if_rdata=0 and d_rdata=0, with all outputs taking these values after the reset edge.
REQ-035 Reset in BUSY_x or RESP_x SHALL abandon the transaction without issuing an ack; a mem_ack arriving after reset SHALL set proto_err per REQ-030.
REQ-036 Requests held across reset deassertion SHALL be arbitrated normally from IDLE on the first edge after reset falls.

Verification
REQ-037 Scenario: if_req with if_addr=0x00100000, mem_ack in the first BUSY cycle with rdata=0x24080005 -> mem_req for 1 cycle with mem_addr=0x00100000, mem_we=0, be=F; then if_ack for 1 cycle with if_rdata=0x24080005, 3 cycles from request to IDLE.
REQ-038 Scenario: simultaneous if_req and d_req (store, addr 0x200, wdata 0xDEADBEEF, be=4'b0011) -> data is granted first with mem_we=1 and be=3; fetch is granted only after d_ack.
REQ-039 Scenario: d_req re-asserted continuously with if_req held, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes; streak reads 0 after the fetch grant.
REQ-040 Scenario: memory waits 5 cycles before mem_ack -> mem_req stays high and mem_* stays stable for 5 cycles; exactly one ack follows.
REQ-041 Scenario: reset asserted in BUSY_D, then mem_ack pulsed 1 cycle after reset falls -> no d_ack, FSM in IDLE, proto_err=1.
REQ-042 Scenario: mem_ack pulsed in IDLE with no requests -> proto_err=1, no ack on either port, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates between an instruction-fetch port and a data
// port for one shared single-outstanding memory port. Data wins by default.
// A streak counter stops a continuous data stream from starving fetch.
module mem_port_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  // shared memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP_I,
    RESP_D
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t            r_state;
  state_t            w_next_state;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_busy;
  logic [3:0]        r_streak;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;
  logic              r_proto_err;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and grant decision; grants happen only from IDLE.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    w_next_state = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (d_req && !(if_req && (r_streak == STREAK_MAX))) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end else if (if_req) begin
          w_grant_i    = 1'b1;
          w_next_state = BUSY_I;
        end
      end
      BUSY_I:  if (mem_ack) w_next_state = RESP_I;
      BUSY_D:  if (mem_ack) w_next_state = RESP_D;
      RESP_I:  w_next_state = IDLE;
      RESP_D:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

  // Latch the granted request; held untouched until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'h0;
    end else if (w_grant_d) begin
      r_mem_we    <= d_we;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
      r_mem_be    <= d_be;
    end else if (w_grant_i) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= if_addr;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'hF;
    end
  end

  // Capture read data for the port that owns the outstanding access.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else if (mem_ack) begin
      if (r_state == BUSY_I) r_if_rdata <= mem_rdata;
      if (r_state == BUSY_D) r_d_rdata  <= mem_rdata;
    end
  end

  // Count consecutive data grants taken while fetch was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_streak <= 4'd0;
    end else if (w_grant_d) begin
      if (!if_req)                     r_streak <= 4'd0;
      else if (r_streak != STREAK_MAX) r_streak <= r_streak + 4'd1;
    end else if (w_grant_i) begin
      r_streak <= 4'd0;
    end
  end

  // Sticky flag: memory acknowledged while nothing was outstanding.
  always_ff @(posedge clk) begin
    if (reset)                 r_proto_err <= 1'b0;
    else if (mem_ack && !w_busy) r_proto_err <= 1'b1;
  end

  assign mem_req   = w_busy;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign if_ack    = (r_state == RESP_I);
  assign d_ack     = (r_state == RESP_D);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign proto_err = r_proto_err;

endmodule
